// File: rtl/alu_issue_if.sv
// Issue handshake, ALU operand/result bus and result handshake for alu_issue.
// slave = the issue block, master = the environment (issuer, ALU and consumer).
interface alu_issue_if;
   localparam int unsigned DW = 32;
   localparam int unsigned CW = 2;

   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] instr;
   logic [DW-1:0] rs_val;
   logic [DW-1:0] rt_val;
   logic [DW-1:0] alu_A;
   logic [DW-1:0] alu_B;
   logic [CW-1:0] alu_ctrl;
   logic [DW-1:0] alu_R;
   logic          alu_zero;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_result;
   logic          out_zero;
   logic          out_illegal;
   logic          out_ovf;

   modport slave (
      input  in_valid, instr, rs_val, rt_val, alu_R, alu_zero, out_ready,
      output in_ready, alu_A, alu_B, alu_ctrl,
             out_valid, out_result, out_zero, out_illegal, out_ovf
   );

   modport master (
      output in_valid, instr, rs_val, rt_val, alu_R, alu_zero, out_ready,
      input  in_ready, alu_A, alu_B, alu_ctrl,
             out_valid, out_result, out_zero, out_illegal, out_ovf
   );
endinterface

// File: rtl/alu_issue.sv
// Decodes one instruction, issues operands to an external registered ALU and holds the result.
// Optional feature macro ALU_ISSUE_OVF_EN adds signed-overflow reporting on out_ovf.
module alu_issue (
   input  logic       clk,
   input  logic       reset,
   alu_issue_if.slave bus
);
   localparam int unsigned DW    = 32;
   localparam int unsigned CW    = 2;
   localparam int unsigned IMM_W = 16;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_XOR   = 6'h26;

   localparam logic [CW-1:0] CTRL_ADD  = 2'b00;
   localparam logic [CW-1:0] CTRL_SUB  = 2'b01;
   localparam logic [CW-1:0] CTRL_XOR  = 2'b10;
   localparam logic [CW-1:0] CTRL_NONE = 2'b11;

   typedef enum logic [1:0] {IDLE, EXEC, CAPT, DONE} state_e;

   state_e        state_q, state_d;
   logic          in_ready_q, in_ready_d;
   logic          out_valid_q, out_valid_d;
   logic [DW-1:0] alu_a_q, alu_a_d;
   logic [DW-1:0] alu_b_q, alu_b_d;
   logic [CW-1:0] alu_ctrl_q, alu_ctrl_d;
   logic [DW-1:0] out_result_q, out_result_d;
   logic          out_zero_q, out_zero_d;
   logic          out_illegal_q, out_illegal_d;

   logic             dec_legal;
   logic [CW-1:0]    dec_ctrl;
   logic [DW-1:0]    dec_b;
   logic [IMM_W-1:0] imm;
   logic             unused_instr;

   assign imm          = bus.instr[IMM_W-1:0];
   assign unused_instr = ^bus.instr[25:16];

   // Instruction decode: legality, ALU op and operand B source
   always_comb begin
      dec_legal = 1'b1;
      dec_ctrl  = CTRL_NONE;
      dec_b     = bus.rt_val;
      case (bus.instr[31:26])
         OP_RTYPE: begin
            case (bus.instr[5:0])
               FN_ADD:  dec_ctrl  = CTRL_ADD;
               FN_SUB:  dec_ctrl  = CTRL_SUB;
               FN_XOR:  dec_ctrl  = CTRL_XOR;
               default: dec_legal = 1'b0;
            endcase
         end
         OP_ADDI: begin
            dec_ctrl = CTRL_ADD;
            dec_b    = {{(DW-IMM_W){imm[IMM_W-1]}}, imm};
         end
         OP_XORI: begin
            dec_ctrl = CTRL_XOR;
            dec_b    = {{(DW-IMM_W){1'b0}}, imm};
         end
         default: dec_legal = 1'b0;
      endcase
   end

`ifdef ALU_ISSUE_OVF_EN
   logic out_ovf_q, out_ovf_d;
   logic ovf;

   // Signed overflow of the operation the ALU just completed
   always_comb begin
      ovf = 1'b0;
      case (alu_ctrl_q)
         CTRL_ADD: ovf = (alu_a_q[DW-1] == alu_b_q[DW-1]) && (bus.alu_R[DW-1] != alu_a_q[DW-1]);
         CTRL_SUB: ovf = (alu_a_q[DW-1] != alu_b_q[DW-1]) && (bus.alu_R[DW-1] != alu_a_q[DW-1]);
         default:  ovf = 1'b0;
      endcase
   end
`endif

   always_comb begin
      state_d       = state_q;
      alu_a_d       = alu_a_q;
      alu_b_d       = alu_b_q;
      alu_ctrl_d    = alu_ctrl_q;
      out_result_d  = out_result_q;
      out_zero_d    = out_zero_q;
      out_illegal_d = out_illegal_q;
`ifdef ALU_ISSUE_OVF_EN
      out_ovf_d     = out_ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               if (dec_legal) begin
                  alu_a_d    = bus.rs_val;
                  alu_b_d    = dec_b;
                  alu_ctrl_d = dec_ctrl;
                  state_d    = EXEC;
               end else begin
                  // Undecodable: skip the ALU and report immediately
                  alu_ctrl_d    = CTRL_NONE;
                  out_result_d  = '0;
                  out_zero_d    = 1'b0;
                  out_illegal_d = 1'b1;
`ifdef ALU_ISSUE_OVF_EN
                  out_ovf_d     = 1'b0;
`endif
                  state_d       = DONE;
               end
            end
         end
         EXEC: state_d = CAPT;
         CAPT: begin
            out_result_d  = bus.alu_R;
            out_zero_d    = bus.alu_zero;
            out_illegal_d = 1'b0;
`ifdef ALU_ISSUE_OVF_EN
            out_ovf_d     = ovf;
`endif
            state_d       = DONE;
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         in_ready_q    <= 1'b1;
         out_valid_q   <= 1'b0;
         alu_a_q       <= '0;
         alu_b_q       <= '0;
         alu_ctrl_q    <= CTRL_NONE;
         out_result_q  <= '0;
         out_zero_q    <= 1'b0;
         out_illegal_q <= 1'b0;
`ifdef ALU_ISSUE_OVF_EN
         out_ovf_q     <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         in_ready_q    <= in_ready_d;
         out_valid_q   <= out_valid_d;
         alu_a_q       <= alu_a_d;
         alu_b_q       <= alu_b_d;
         alu_ctrl_q    <= alu_ctrl_d;
         out_result_q  <= out_result_d;
         out_zero_q    <= out_zero_d;
         out_illegal_q <= out_illegal_d;
`ifdef ALU_ISSUE_OVF_EN
         out_ovf_q     <= out_ovf_d;
`endif
      end
   end

   assign bus.in_ready    = in_ready_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.alu_A       = alu_a_q;
   assign bus.alu_B       = alu_b_q;
   assign bus.alu_ctrl    = alu_ctrl_q;
   assign bus.out_result  = out_result_q;
   assign bus.out_zero    = out_zero_q;
   assign bus.out_illegal = out_illegal_q;
`ifdef ALU_ISSUE_OVF_EN
   assign bus.out_ovf     = out_ovf_q;
`else
   assign bus.out_ovf     = 1'b0;
`endif
endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: fixed vectors, reset corner cases and random instructions vs a reference model.
// Follows ALU_ISSUE_OVF_EN if it is defined for the build.
module tb_alu_issue;
`ifdef ALU_ISSUE_OVF_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;
   logic [31:0] mdl_a;
   logic [31:0] mdl_b;

   alu_issue_if bus ();
   alu_issue dut (.clk(clk), .reset(reset), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Registered external ALU; shares the reset line
   function automatic logic [31:0] alu_fn(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b);
      case (c)
         2'b00:   return a + b;
         2'b01:   return a - b;
         2'b10:   return a ^ b;
         default: return 32'h0;
      endcase
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.alu_R    <= 32'h0;
         bus.alu_zero <= 1'b1;
      end else begin
         bus.alu_R    <= alu_fn(bus.alu_ctrl, bus.alu_A, bus.alu_B);
         bus.alu_zero <= (alu_fn(bus.alu_ctrl, bus.alu_A, bus.alu_B) == 32'h0);
      end
   end

   typedef struct {
      logic [1:0]  ctrl;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] result;
      logic        zero;
      logic        illegal;
      logic        ovf;
   } exp_t;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] rs;
      logic [31:0] rt;
      int          hold;
      logic [31:0] result;
      logic        zero;
      logic        illegal;
      logic        ovf;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference: instruction semantics computed with plain arithmetic
   function automatic exp_t model(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
      exp_t        e;
      logic [5:0]  op;
      logic [5:0]  fn;
      logic [15:0] imm;
      longint      sa, sb, sr;
      op = ins[31:26];
      fn = ins[5:0];
      imm = ins[15:0];
      e.a = rs;
      e.b = rt;
      e.illegal = 1'b0;
      e.ctrl = 2'd3;
      if (op == 6'h00 && fn == 6'h20)      e.ctrl = 2'd0;
      else if (op == 6'h00 && fn == 6'h22) e.ctrl = 2'd1;
      else if (op == 6'h00 && fn == 6'h26) e.ctrl = 2'd2;
      else if (op == 6'h08) begin e.ctrl = 2'd0; e.b = 32'($signed(imm)); end
      else if (op == 6'h0E) begin e.ctrl = 2'd2; e.b = 32'(imm); end
      else e.illegal = 1'b1;
      if (e.illegal) begin
         e.a = mdl_a;
         e.b = mdl_b;
         e.result = 32'h0;
         e.zero = 1'b0;
         e.ovf = 1'b0;
         return e;
      end
      sa = longint'($signed(e.a));
      sb = longint'($signed(e.b));
      sr = 0;
      case (e.ctrl)
         2'd0: begin e.result = e.a + e.b; sr = sa + sb; end
         2'd1: begin e.result = e.a - e.b; sr = sa - sb; end
         default: begin e.result = e.a ^ e.b; sr = longint'($signed(e.result)); end
      endcase
      e.zero = (e.result == 32'h0);
      e.ovf  = OVF_EN && (sr != longint'($signed(e.result)));
      return e;
   endfunction

   task automatic chk_outs(input string nm, input exp_t e);
      chk({nm, "_valid"}, 32'(bus.out_valid), 32'd1);
      chk({nm, "_result"}, bus.out_result, e.result);
      chk({nm, "_zero"}, 32'(bus.out_zero), 32'(e.zero));
      chk({nm, "_illegal"}, 32'(bus.out_illegal), 32'(e.illegal));
      chk({nm, "_ovf"}, 32'(bus.out_ovf), 32'(e.ovf));
   endtask

   // One instruction: accept, latency, result, optional back-pressure, completion
   task automatic do_op(input string nm, input logic [31:0] ins, input logic [31:0] rs,
                        input logic [31:0] rt, input int hold, input exp_t e);
      int n;
      int lat;
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
      chk({nm, "_in_ready"}, 32'(bus.in_ready), 32'd1);
      bus.instr = ins;
      bus.rs_val = rs;
      bus.rt_val = rt;
      bus.in_valid = 1'b1;
      bus.out_ready = (hold == 0);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.instr = $urandom();
      bus.rs_val = $urandom();
      bus.rt_val = $urandom();
      mdl_a = e.a;
      mdl_b = e.b;
      chk({nm, "_ctrl"}, 32'(bus.alu_ctrl), 32'(e.ctrl));
      chk({nm, "_A"}, bus.alu_A, e.a);
      chk({nm, "_B"}, bus.alu_B, e.b);
      lat = 1;
      while (bus.out_valid !== 1'b1 && lat < 10) begin @(posedge clk); #1; lat++; end
      chk({nm, "_latency"}, 32'(lat), e.illegal ? 32'd1 : 32'd3);
      chk_outs(nm, e);
      if (hold > 0) begin
         bus.in_valid = 1'b1;
         bus.instr = 32'h0000_0020;
         bus.rs_val = ~e.a;
         bus.rt_val = ~e.b;
         for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            chk({nm, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
            chk_outs({nm, "_hold"}, e);
            chk({nm, "_hold_A"}, bus.alu_A, e.a);
         end
         bus.out_ready = 1'b1;
      end
      @(posedge clk); #1;
      chk({nm, "_done_valid"}, 32'(bus.out_valid), 32'd0);
      chk({nm, "_done_in_ready"}, 32'(bus.in_ready), 32'd1);
      chk({nm, "_no_accept_A"}, bus.alu_A, e.a);
      chk({nm, "_no_accept_ctrl"}, 32'(bus.alu_ctrl), 32'(e.ctrl));
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t        vecs[11];
      exp_t        e;
      logic [31:0] edges[4];
      logic [31:0] ins, rs, rt;
      logic        seen;

      n_cmp = 0;
      n_err = 0;
      mdl_a = 32'h0;
      mdl_b = 32'h0;
      edges[0] = 32'h0000_0000;
      edges[1] = 32'h7FFF_FFFF;
      edges[2] = 32'h8000_0000;
      edges[3] = 32'hFFFF_FFFF;

      vecs[0]  = '{32'h0022_1820, 32'd5,         32'd7,         0, 32'd12,        1'b0, 1'b0, 1'b0};
      vecs[1]  = '{32'h0022_1822, 32'h1234,      32'h1234,      0, 32'd0,         1'b1, 1'b0, 1'b0};
      vecs[2]  = '{32'h2022_FFFF, 32'd10,        32'd99,        5, 32'd9,         1'b0, 1'b0, 1'b0};
      vecs[3]  = '{32'hFC00_0000, 32'd3,         32'd4,         0, 32'd0,         1'b0, 1'b1, 1'b0};
      vecs[4]  = '{32'h0022_1820, 32'h7FFF_FFFF, 32'd1,         0, 32'h8000_0000, 1'b0, 1'b0, 1'b1};
      vecs[5]  = '{32'h3822_0001, 32'h7FFF_FFFF, 32'd1,         0, 32'h7FFF_FFFE, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{32'h0022_1822, 32'h8000_0000, 32'd1,         1, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1};
      vecs[7]  = '{32'h0022_1826, 32'hFFFF_0000, 32'h00FF_FF00, 0, 32'hFF00_FF00, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{32'h0022_1821, 32'd1,         32'd2,         2, 32'd0,         1'b0, 1'b1, 1'b0};
      vecs[9]  = '{32'h3820_8000, 32'd0,         32'd5,         0, 32'h0000_8000, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{32'h2020_8000, 32'd0,         32'd5,         0, 32'hFFFF_8000, 1'b0, 1'b0, 1'b0};

      reset = 1'b1;
      bus.in_valid = 1'b0;
      bus.instr = 32'h0;
      bus.rs_val = 32'h0;
      bus.rt_val = 32'h0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_A", bus.alu_A, 32'h0);
      chk("rst_B", bus.alu_B, 32'h0);
      chk("rst_ctrl", 32'(bus.alu_ctrl), 32'd3);
      chk("rst_result", bus.out_result, 32'h0);
      chk("rst_zero", 32'(bus.out_zero), 32'd0);
      chk("rst_illegal", 32'(bus.out_illegal), 32'd0);
      chk("rst_ovf", 32'(bus.out_ovf), 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 11; i++) begin
         e = model(vecs[i].instr, vecs[i].rs, vecs[i].rt);
         e.result  = vecs[i].result;
         e.zero    = vecs[i].zero;
         e.illegal = vecs[i].illegal;
         e.ovf     = OVF_EN && vecs[i].ovf;
         do_op($sformatf("vec%0d", i), vecs[i].instr, vecs[i].rs, vecs[i].rt, vecs[i].hold, e);
      end

      // Reset while the result is being captured: no handshake may follow
      bus.instr = 32'h0022_1820;
      bus.rs_val = 32'd40;
      bus.rt_val = 32'd2;
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      chk("capt_in_ready", 32'(bus.in_ready), 32'd0);
      reset = 1'b1;
      #1;
      chk("async_rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("async_rst_ctrl", 32'(bus.alu_ctrl), 32'd3);
      chk("async_rst_A", bus.alu_A, 32'h0);
      mdl_a = 32'h0;
      mdl_b = 32'h0;
      @(posedge clk); #1;
      reset = 1'b0;
      seen = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
         if (bus.out_valid === 1'b1) seen = 1'b1;
      end
      chk("rst_capt_no_valid", 32'(seen), 32'd0);
      chk("rst_capt_in_ready", 32'(bus.in_ready), 32'd1);
      e = model(32'h0022_1820, 32'd1, 32'd1);
      e.result = 32'd2;
      do_op("post_rst_add", 32'h0022_1820, 32'd1, 32'd1, 0, e);

      for (int i = 0; i < 80; i++) begin
         ins = $urandom();
         case ($urandom_range(0, 6))
            0: begin ins[31:26] = 6'h00; ins[5:0] = 6'h20; end
            1: begin ins[31:26] = 6'h00; ins[5:0] = 6'h22; end
            2: begin ins[31:26] = 6'h00; ins[5:0] = 6'h26; end
            3: ins[31:26] = 6'h08;
            4: ins[31:26] = 6'h0E;
            5: ins[31:26] = 6'h00;
            default: ;
         endcase
         rs = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : $urandom();
         rt = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : $urandom();
         if ($urandom_range(0, 7) == 0) rt = rs;
         e = model(ins, rs, rt);
         do_op($sformatf("rnd%0d", i), ins, rs, rt, $urandom_range(0, 2), e);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 32-bit data and 2-bit ALU control.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  instruction and operands present.
REQ-005 in_ready  output  1  block accepts an instruction this cycle.
REQ-006 instr  input  32  instruction word; opcode [31:26], funct [5:0], imm [15:0].
REQ-007 rs_val  input  32  first source register value.
REQ-008 rt_val  input  32  second source register value.
REQ-009 alu_A  output  32  registered operand A to the ALU.
REQ-010 alu_B  output  32  registered operand B to the ALU.
REQ-011 alu_ctrl  output  2  registered ALU op: 00 ADD, 01 SUB, 10 XOR, 11 none (ALU yields 0).
REQ-012 alu_R  input  32  registered ALU result, valid one clock after operands are sampled.
REQ-013 alu_zero  input  1  ALU zero flag for alu_R.
REQ-014 out_valid  output  1  result holding.
REQ-015 out_ready  input  1  consumer takes the result.
REQ-016 out_result  output  32  captured result.
REQ-017 out_zero  output  1  captured zero flag.
REQ-018 out_illegal  output  1  instruction was not decodable.
REQ-019 out_ovf  output  1  signed overflow flag (see Configuration).

Function
REQ-020 The FSM SHALL have states IDLE, EXEC, CAPT and DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-021 Decode: opcode 0x00 with funct 0x20/0x22/0x26 SHALL give ctrl 00/01/10 with B = rt_val; opcode 0x08 (ADDI) SHALL give ctrl 00 with B = sign-extended imm; opcode 0x0E (XORI) SHALL give ctrl 10 with B = zero-extended imm; A = rs_val in all legal cases.
REQ-022 Legal accept (IDLE, in_valid=1): the block SHALL load alu_A/alu_B/alu_ctrl and move to EXEC.
REQ-023 EXEC SHALL last one cycle (the ALU samples operands at its closing edge), then move to CAPT.
REQ-024 At the closing edge of CAPT, the block SHALL register alu_R into out_result and alu_zero into out_zero, clear out_illegal, and move to DONE; out_valid is therefore high 3 cycles after the accept edge.
REQ-025 Illegal accept: the block SHALL set alu_ctrl=11, leave alu_A/alu_B unchanged, set out_result=0, out_zero=0, out_illegal=1, out_ovf=0, and move directly to DONE (out_valid high 1 cycle after accept).
REQ-026 In DONE, outputs SHALL hold stable while out_ready=0; when out_ready=1 the block SHALL return to IDLE at that edge.
REQ-027 alu_A/alu_B/alu_ctrl SHALL hold their values from accept until the next accept.
REQ-028 An instruction offered in the same cycle that DONE completes SHALL NOT be accepted (in_ready=0); it is taken at the earliest in the following IDLE cycle.

Reset
REQ-029 On reset assertion, the block SHALL immediately enter IDLE with in_ready=1 and out_valid=0; alu_A=0, alu_B=0, alu_ctrl=11, out_result=0, out_zero=0, out_illegal=0, out_ovf=0.
REQ-030 Reset during EXEC, CAPT or DONE SHALL discard the in-flight result with no output handshake.
REQ-031 Reset SHALL be held for at least one clk edge so that the ALU, which shares the reset line, also clears.

Configuration
REQ-032 Feature macro ALU_ISSUE_OVF_EN.
REQ-033 With ALU_ISSUE_OVF_EN defined, at the closing edge of CAPT the block SHALL set out_ovf as follows: ADD: sign(A)==sign(B) and sign(R)!=sign(A); SUB: sign(A)!=sign(B) and sign(R)!=sign(A); XOR: 0.
REQ-034 With ALU_ISSUE_OVF_EN not defined, out_ovf SHALL be constant 0 and no overflow logic SHALL be present.

Verification
REQ-035 R-type ADD, rs=5, rt=7, out_ready=1 -> out_result=12, out_zero=0, out_illegal=0; out_valid high for exactly 1 cycle, 3 cycles after accept.
REQ-036 R-type SUB, rs=rt=0x1234 -> out_result=0, out_zero=1; ADDI rs=10, imm=0xFFFF -> out_result=9.
REQ-037 Opcode 0x3F -> alu_ctrl=11, out_illegal=1, out_result=0, out_valid 1 cycle after accept.
REQ-038 out_ready held low 5 cycles in DONE with in_valid=1 -> outputs stable, in_ready=0, no second accept until 1 cycle after out_ready=1.
REQ-039 With ALU_ISSUE_OVF_EN defined, ADD 0x7FFFFFFF+1 -> out_result=0x80000000, out_ovf=1; XORI with the same operands -> out_ovf=0; without the macro -> out_ovf=0.
REQ-040 Reset pulse during CAPT -> out_valid never asserts, in_ready=1 after reset, next ADD 1+1 -> out_result=2.
